modular_addsub_pipe: RTL

//  Multi-lane, two-stage pipelined modular adder/subtractor with valid/ready flow control.

---
 rtl/modular_addsub_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/modular_addsub_pipe.sv
// Multi-lane (x +/- y) mod M, 2-stage pipe; 2-cycle latency, 1 beat/cycle.
// Back-pressure: in_ready = out_ready | not-full, combinational, no skid buffer; stalled stages hold.
module modular_addsub_pipe #(
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] M          = 64'hFFFF_FFFF_0000_0001,
   parameter int                    LANES      = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_mode,
   input  logic [LANES*DATA_WIDTH-1:0] in_x,
   input  logic [LANES*DATA_WIDTH-1:0] in_y,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_z,
   output logic                        range_err,
   input  logic                        clr_err
);
   localparam int W = DATA_WIDTH;

   logic         v1, v2, mode1;
   logic         adv1, adv2, accept, any_big;
   logic [W:0]   r1     [LANES];
   logic [W-1:0] z2     [LANES];
   logic [W-1:0] z_next [LANES];

   assign adv2      = out_ready | ~v2;
   assign adv1      = adv2 | ~v1;
   assign in_ready  = adv1;
   assign accept    = in_valid & adv1;
   assign out_valid = v2;

   always_comb begin
      any_big = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if ((in_x[i*W +: W] >= M) || (in_y[i*W +: W] >= M)) begin
            any_big = 1'b1;
         end
      end
   end

   // r1[W] is the carry for add and the borrow for subtract; the modular
   // correction only needs the low W bits because it wraps mod 2^W anyway.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         z_next[i] = r1[i][W-1:0];
         if (mode1) begin
            if (r1[i][W]) z_next[i] = r1[i][W-1:0] + M;
         end else begin
            if (r1[i] >= {1'b0, M}) z_next[i] = r1[i][W-1:0] - M;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         mode1 <= 1'b0;
         for (int i = 0; i < LANES; i++) r1[i] <= '0;
      end else if (adv1) begin
         v1 <= in_valid;
         if (in_valid) begin
            mode1 <= in_mode;
            for (int i = 0; i < LANES; i++) begin
               if (in_mode) r1[i] <= {1'b0, in_x[i*W +: W]} - {1'b0, in_y[i*W +: W]};
               else         r1[i] <= {1'b0, in_x[i*W +: W]} + {1'b0, in_y[i*W +: W]};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         for (int i = 0; i < LANES; i++) z2[i] <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            for (int i = 0; i < LANES; i++) z2[i] <= z_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                range_err <= 1'b0;
      else if (accept && any_big) range_err <= 1'b1;
      else if (clr_err)          range_err <= 1'b0;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign out_z[g*W +: W] = z2[g];
   end
endmodule
